mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control FSM: decodes op/funct from the instruction register and drives datapath
//  enables, mux selects and the 3-bit alucontrol code consumed by the ALU (add 010, sub 110,
//  and 000, or 001, slt 111). Consumes the ALU zero flag for beq. Sits between IR and datapath.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch if equal
//  OP_ADDI   6'b001000  add immediate
//  OP_J      6'b000010  jump
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  reset      in   1  synchronous, active-high
//  op         in   6  instr[31:26] from IR
//  funct      in   6  instr[5:0] from IR
//  zero       in   1  ALU zero flag (aluout == 0)
//  pcen       out  1  PC write enable = pcwrite | (branch & zero)
//  iord       out  1  memory address select: 0 = PC, 1 = ALUOut
//  memwrite   out  1  data memory write strobe
//  irwrite    out  1  instruction register load
//  regdst     out  1  write reg select: 0 = rt, 1 = rd
//  memtoreg   out  1  writeback select: 0 = ALUOut, 1 = Data
//  regwrite   out  1  register file write enable
//  alusrca    out  1  ALU A: 0 = PC, 1 = A reg
//  alusrcb    out  2  ALU B: 00 = B reg, 01 = 4, 10 = signimm, 11 = signimm<<2
//  pcsrc      out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
//  alucontrol out  3  ALU operation code
//  illegal    out  1  one-cycle pulse in DECODE when op/funct are unsupported
//  state      out  4  current state, debug only
// BEHAVIOUR
//  - Moore FSM, 4-bit state register; all outputs are combinational from state (plus funct/zero).
//  - States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7,
//    BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are unreachable and go to FETCH next cycle.
//  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
//  - DECODE: alusrca=0, alusrcb=11, aluop=add. Next state by op: LW/SW->MEMADR, RTYPE->RTYPEEX,
//    BEQ->BEQEX, ADDI->ADDIEX, J->JEX. Any other op, or RTYPE with unsupported funct: illegal=1
//    and next state is FETCH. No write of any kind happens for an illegal instruction.
//  - MEMADR: alusrca=1, alusrcb=10, add -> MEMRD if LW, MEMWR if SW.
//  - MEMRD: iord=1 -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
//  - MEMWR: iord=1, memwrite=1 -> FETCH.
//  - RTYPEEX: alusrca=1, alusrcb=00, aluop=funct -> RTYPEWB.
//    RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
//  - BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 -> FETCH.
//  - ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
//  - JEX: pcsrc=10, pcwrite=1 -> FETCH.
//  - Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
//  - alucontrol: aluop add -> 010, sub -> 110. In funct mode: 100000 -> 010, 100010 -> 110,
//    100100 -> 000, 100101 -> 001, 101010 -> 111. alucontrol is never X. States that do not
//    name an ALU op drive 010.
//  - Signals not listed for a state are 0 (alusrcb and pcsrc are 00).
//  - Reset: while reset=1, pcen, irwrite, regwrite, memwrite and illegal are forced to 0.
//    The state register loads FETCH at the edge. Reset in any state, including mid-instruction,
//    abandons the instruction; the first cycle after reset deasserts is FETCH with pcen=1.
//  - beq: pcen = branch & zero in BEQEX only. zero is ignored in every other state.
// TESTING
//  1. reset=1 for 2 cycles from an arbitrary state -> state=0, pcen=0. After release,
//     cycle 1: state=0, pcen=1, irwrite=1, alucontrol=010.
//  2. op=100011 (lw) -> states 0,1,2,3,4,0. regwrite=1 only in state 4, with memtoreg=1, regdst=0.
//  3. R-type, funct=101010 -> RTYPEEX alucontrol=111. funct=100100 -> 000.
//     RTYPEWB: regwrite=1, regdst=1.
//  4. op=000100, zero=1 -> in BEQEX pcen=1, pcsrc=01, alucontrol=110. With zero=0 -> pcen=0.
//     3 cycles total in both cases.
//  5. op=111111, then R-type with funct=000000 -> illegal=1 in DECODE, next state=0,
//     no memwrite/regwrite/pcen pulse.
//  6. Assert reset in MEMWR of a sw -> memwrite=0 that cycle, next state=FETCH.

Source files
------------

// File: rtl/mc_controller_if.sv
// Controller-to-datapath bundle: instruction fields and zero flag in, datapath controls out.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore state machine decoding op/funct into datapath enables,
// mux selects and the 3-bit ALU control code.
module mc_controller (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  typedef enum logic [1:0] {AluAdd, AluSub, AluFunct} aluop_e;

  state_e     state_q, state_d;
  aluop_e     aluop;
  logic       pcwrite, branch, funct_ok;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    funct_ok = 1'b0;
    case (bus.funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = StFetch;
    aluop    = AluAdd;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE: begin
            if (funct_ok) state_d = StRtypeEx;
            else          illegal = 1'b1;
          end
          OP_BEQ:  state_d = StBeqEx;
          OP_ADDI: state_d = StAddiEx;
          OP_J:    state_d = StJEx;
          default: illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.op == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = AluFunct;
        state_d = StRtypeWb;
      end
      StRtypeWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBeqEx: begin
        alusrca = 1'b1;
        aluop   = AluSub;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: regwrite = 1'b1;
      StJEx: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = StFetch;  // unreachable codes 12-15 recover to fetch
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      AluSub: alucontrol = 3'b110;
      AluFunct: begin
        case (bus.funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Write strobes are masked while reset is held so an abandoned instruction leaves no trace.
  assign bus.pcen       = (pcwrite | (branch & bus.zero)) & ~reset;
  assign bus.irwrite    = irwrite & ~reset;
  assign bus.regwrite   = regwrite & ~reset;
  assign bus.memwrite   = memwrite & ~reset;
  assign bus.illegal    = illegal & ~reset;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;

endmodule
